// File: rtl/ifetch_axi_bridge.sv
// Fetch-to-AXI read bridge: single-beat AR/R with flush-driven discard of stale R beats; data_ok same cycle as R beat.
// Backpressure: inst_addr_ok low while AR pending or MAX_OUTSTANDING reached; IFETCH_RBUF_EN registers data_ok/rdata (+1 cycle).
module ifetch_axi_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        flush,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, AR_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] cancel_cnt;
  logic          accept;
  logic          beat;
  logic          deliver;

  assign arid   = ARID;
  assign rready = 1'b1;

  // A beat with nothing outstanding is a protocol error and is ignored outright.
  assign beat    = rvalid & (outstanding != '0);
  assign accept  = inst_req & ~flush & (state == IDLE) & (outstanding < MAX_CNT);
  assign deliver = beat & (cancel_cnt == '0) & ~flush;

  assign inst_addr_ok = accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      arvalid     <= 1'b0;
      araddr      <= '0;
      outstanding <= '0;
      cancel_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            araddr  <= inst_addr;
            arvalid <= 1'b1;
            state   <= AR_WAIT;
          end
        end
        AR_WAIT: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      case ({accept, beat})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      // Everything still owed by the slave, including a pending AR, is stale after a flush.
      if (flush) begin
        cancel_cnt <= outstanding - CW'(beat);
      end else if (beat && cancel_cnt != '0) begin
        cancel_cnt <= cancel_cnt - CW'(1);
      end
    end
  end

`ifdef IFETCH_RBUF_EN
  logic        data_ok_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= deliver;
      if (deliver) begin
        rdata_q <= rdata;
      end
    end
  end

  assign inst_data_ok = data_ok_q & ~flush;
  assign inst_rdata   = rdata_q;
`else
  assign inst_data_ok = deliver;
  assign inst_rdata   = rdata;
`endif

endmodule

// File: tb/tb_ifetch_axi_bridge.sv
// Bench for ifetch_axi_bridge (default build): directed vector table, hand sequences, random run vs queue model.
module tb_ifetch_axi_bridge;

  localparam int MAX = 2;
  localparam logic [3:0] ID = 4'd5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        flush;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_axi_bridge #(.MAX_OUTSTANDING(MAX), .ARID(ID)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .flush(flush),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        fl;
    logic        ar;
    logic        rv;
    logic [31:0] rd;
    logic        ok;
    logic        arv;
    logic [31:0] aa;
    logic        dok;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic req, input logic [31:0] addr, input logic fl, input logic ar,
                     input logic rv, input logic [31:0] rd, input logic ok, input logic arv,
                     input logic [31:0] aa, input logic dok, input logic [31:0] rdat);
    vec_t v;
    v.req = req; v.addr = addr; v.fl = fl; v.ar = ar; v.rv = rv; v.rd = rd;
    v.ok = ok; v.arv = arv; v.aa = aa; v.dok = dok; v.rdat = rdat;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic fl,
                       input logic ar, input logic rv, input logic [31:0] rd);
    inst_req = req; inst_addr = addr; flush = fl; arready = ar; rvalid = rv; rdata = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: one entry per accepted-but-unreturned read; flush marks them all dead.
  bit          live_q[$];
  bit          ar_pend;
  logic [31:0] ar_addr;

  initial begin
    logic exp_ok, exp_dok, bt;
    drive(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_arvalid", {31'd0, arvalid}, 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("reset_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("reset_rdata", inst_rdata, 32'd0);
    chk("arid", {28'd0, arid}, {28'd0, ID});
    chk("rready", {31'd0, rready}, 32'd1);
    resetn = 1'b1;
    cyc();

    //   req addr          fl ar rv rdata          ok arv araddr        dok rdata
    add(1, 32'h1C000000, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C000000, 0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'h02800C0C, 0, 0, 32'h0,        1, 32'h02800C0C);
    add(1, 32'h1C000004, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(1, 32'h1C000008, 0, 1, 0, 32'h0,        0, 1, 32'h1C000004, 0, 32'h0);
    add(1, 32'h1C000008, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(1, 32'h1C00000C, 0, 1, 0, 32'h0,        0, 1, 32'h1C000008, 0, 32'h0);
    add(1, 32'h1C00000C, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(1, 32'h1C00000C, 0, 1, 1, 32'h11111111, 0, 0, 32'h0,        1, 32'h11111111);
    add(1, 32'h1C00000C, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C00000C, 0, 32'h0);
    add(0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'hAAAA0000, 0, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'hBBBB0000, 0, 0, 32'h0,        0, 32'h0);
    add(1, 32'h1C008000, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C008000, 0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'hCCCC0000, 0, 0, 32'h0,        1, 32'hCCCC0000);
    add(1, 32'h1C000010, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C000010, 0, 32'h0);
    add(1, 32'h1C000014, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C000014, 0, 32'h0);
    add(0, 32'h0,        1, 1, 1, 32'hDDDD0000, 0, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'hEEEE0000, 0, 0, 32'h0,        0, 32'h0);
    add(1, 32'h1C000018, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C000018, 0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'hFFFF0000, 0, 0, 32'h0,        1, 32'hFFFF0000);
    add(1, 32'h1C00001C, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        1, 0, 0, 32'h0,        0, 1, 32'h1C00001C, 0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C00001C, 0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'h12345678, 0, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'h87654321, 0, 0, 32'h0,        0, 32'h0);
    add(1, 32'h1C000020, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 32'h0,        0, 1, 0, 32'h0,        0, 1, 32'h1C000020, 0, 32'h0);
    add(0, 32'h0,        0, 1, 1, 32'h0A0A0A0A, 0, 0, 32'h0,        1, 32'h0A0A0A0A);

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].addr, tbl[i].fl, tbl[i].ar, tbl[i].rv, tbl[i].rd);
      #3;
      chk($sformatf("vec%0d_addr_ok", i), {31'd0, inst_addr_ok}, {31'd0, tbl[i].ok});
      chk($sformatf("vec%0d_arvalid", i), {31'd0, arvalid}, {31'd0, tbl[i].arv});
      if (tbl[i].arv) chk($sformatf("vec%0d_araddr", i), araddr, tbl[i].aa);
      chk($sformatf("vec%0d_data_ok", i), {31'd0, inst_data_ok}, {31'd0, tbl[i].dok});
      if (tbl[i].dok) chk($sformatf("vec%0d_rdata", i), inst_rdata, tbl[i].rdat);
      cyc();
    end

    // AR stall: address held stable, no second accept while arready is low.
    drive(1, 32'h1C000040, 0, 0, 0, 0);
    #3 chk("stall_accept", {31'd0, inst_addr_ok}, 32'd1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h1C000044, 0, 0, 0, 0);
      #3;
      chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
      chk("stall_araddr", araddr, 32'h1C000040);
      chk("stall_no_accept", {31'd0, inst_addr_ok}, 32'd0);
      cyc();
    end
    drive(1, 32'h1C000044, 0, 1, 0, 0);
    #3;
    chk("stall_release_arvalid", {31'd0, arvalid}, 32'd1);
    chk("stall_release_no_accept", {31'd0, inst_addr_ok}, 32'd0);
    cyc();
    drive(1, 32'h1C000044, 0, 0, 0, 0);
    #3;
    chk("stall_done_arvalid", {31'd0, arvalid}, 32'd0);
    chk("stall_next_accept", {31'd0, inst_addr_ok}, 32'd1);
    cyc();
    drive(0, 0, 0, 1, 0, 0);
    #3 chk("stall_second_araddr", araddr, 32'h1C000044);
    cyc();
    drive(0, 0, 0, 0, 1, 32'h00000005);
    #3 chk("stall_beat1", {31'd0, inst_data_ok}, 32'd1);
    cyc();
    drive(0, 0, 0, 0, 1, 32'h00000006);
    #3 chk("stall_beat2_rdata", inst_rdata, 32'h00000006);
    cyc();

    // Reset while AR is pending clears everything without a clock edge.
    drive(1, 32'h1C000080, 0, 0, 0, 0);
    #3 chk("rst_pre_accept", {31'd0, inst_addr_ok}, 32'd1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("rst_pre_arvalid", {31'd0, arvalid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_async_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_async_araddr", araddr, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(1, 32'h1C0000C0, 0, 0, 0, 0);
    #3 chk("rst_first_accept", {31'd0, inst_addr_ok}, 32'd1);
    cyc();
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 32'h0C0C0C0C);
    #3 chk("rst_after_beat", {31'd0, inst_data_ok}, 32'd1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();

    // Randomized run against the queue model.
    ar_pend = 1'b0;
    ar_addr = 32'h1C0000C0;
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom);
      exp_ok  = inst_req && !flush && !ar_pend && (live_q.size() < MAX);
      bt      = rvalid && (live_q.size() > 0);
      exp_dok = 1'b0;
      if (bt) exp_dok = live_q[0] && !flush;
      #3;
      chk("rand_addr_ok", {31'd0, inst_addr_ok}, {31'd0, exp_ok});
      chk("rand_arvalid", {31'd0, arvalid}, {31'd0, ar_pend});
      if (ar_pend) chk("rand_araddr", araddr, ar_addr);
      chk("rand_data_ok", {31'd0, inst_data_ok}, {31'd0, exp_dok});
      if (exp_dok) chk("rand_rdata", inst_rdata, rdata);
      if (flush) foreach (live_q[j]) live_q[j] = 1'b0;
      if (bt) void'(live_q.pop_front());
      if (ar_pend && arready) begin
        ar_pend = 1'b0;
      end else if (exp_ok) begin
        live_q.push_back(1'b1);
        ar_pend = 1'b1;
        ar_addr = inst_addr;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
